// File: rtl/input_debouncer_pkg.sv
// Shared constants and helpers for the pad-input debouncer.
// Defaults assume a 50 MHz sys_clk and a 1 ms sample tick.
package input_debouncer_pkg;

  localparam int DEB_TICK_DIV_50MHZ = 50000;
  localparam int DEB_STABLE_TICKS   = 10;
  localparam int DEB_SYNC_STAGES    = 2;

  localparam int SW_W  = 8;
  localparam int BTN_W = 4;

  typedef enum logic [1:0] {
    EDGE_NONE,
    EDGE_RISE,
    EDGE_FALL
  } edge_e;

  // Counter width for a 0..n-1 range, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One input bit: synchroniser, tick-qualified stability counter,
// registered clean level and one-cycle edge pulses.
module debounce_channel
  import input_debouncer_pkg::*;
#(
  parameter int SYNC_STAGES  = DEB_SYNC_STAGES,
  parameter int STABLE_TICKS = DEB_STABLE_TICKS
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic tick,
  input  logic raw,
  output logic level,
  output logic press_pulse,
  output logic release_pulse
);

  localparam int             CW     = cnt_width(STABLE_TICKS);
  localparam logic [CW-1:0]  C_LAST = CW'(STABLE_TICKS - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_cnt;
  logic [CW-1:0]          w_cnt_next;
  logic                   r_level;
  logic                   w_level_next;
  logic                   r_press;
  logic                   r_release;
  logic                   w_s;
  edge_e                  w_edge;

  assign w_s = r_sync[SYNC_STAGES-1];

  // Any return to the current level discards the partial count.
  always_comb begin
    w_cnt_next   = r_cnt;
    w_level_next = r_level;
    w_edge       = EDGE_NONE;
    if (w_s == r_level) begin
      w_cnt_next = '0;
    end else if (tick) begin
      if (r_cnt == C_LAST) begin
        w_cnt_next   = '0;
        w_level_next = w_s;
        w_edge       = w_s ? EDGE_RISE : EDGE_FALL;
      end else begin
        w_cnt_next = r_cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_sync    <= '0;
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_sync    <= {r_sync[SYNC_STAGES-2:0], raw};
      r_cnt     <= w_cnt_next;
      r_level   <= w_level_next;
      r_press   <= (w_edge == EDGE_RISE);
      r_release <= (w_edge == EDGE_FALL);
    end
  end

  assign level         = r_level;
  assign press_pulse   = r_press;
  assign release_pulse = r_release;

endmodule

// File: rtl/input_debouncer.sv
// Debounces 8 switches and 4 buttons in the sys_clk domain using one
// shared sample-tick prescaler; buttons also get press/release pulses.
module input_debouncer
  import input_debouncer_pkg::*;
#(
  parameter int SYNC_STAGES  = DEB_SYNC_STAGES,
  parameter int TICK_DIV     = DEB_TICK_DIV_50MHZ,
  parameter int STABLE_TICKS = DEB_STABLE_TICKS
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic [SW_W-1:0]  raw_sw,
  input  logic [BTN_W-1:0] raw_btn,
  output logic [SW_W-1:0]  sw,
  output logic [BTN_W-1:0] btn,
  output logic [BTN_W-1:0] btn_press,
  output logic [BTN_W-1:0] btn_release
);

  localparam int            DW       = cnt_width(TICK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);

  logic [DW-1:0]   r_div_cnt;
  logic            w_tick;
  logic [SW_W-1:0] w_sw_press;
  logic [SW_W-1:0] w_sw_release;
  logic            w_unused_pulses;

  // With TICK_DIV=1 the count is pinned at 0 and the tick is always high.
  assign w_tick = (r_div_cnt == DIV_LAST);

  always_ff @(posedge sys_clk) begin
    if (sys_rst || w_tick) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + DW'(1);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < SW_W; gi++) begin : g_sw
      debounce_channel #(
        .SYNC_STAGES  (SYNC_STAGES),
        .STABLE_TICKS (STABLE_TICKS)
      ) u_ch (
        .sys_clk       (sys_clk),
        .sys_rst       (sys_rst),
        .tick          (w_tick),
        .raw           (raw_sw[gi]),
        .level         (sw[gi]),
        .press_pulse   (w_sw_press[gi]),
        .release_pulse (w_sw_release[gi])
      );
    end
    for (gi = 0; gi < BTN_W; gi++) begin : g_btn
      debounce_channel #(
        .SYNC_STAGES  (SYNC_STAGES),
        .STABLE_TICKS (STABLE_TICKS)
      ) u_ch (
        .sys_clk       (sys_clk),
        .sys_rst       (sys_rst),
        .tick          (w_tick),
        .raw           (raw_btn[gi]),
        .level         (btn[gi]),
        .press_pulse   (btn_press[gi]),
        .release_pulse (btn_release[gi])
      );
    end
  endgenerate

  // Switch channels have no pulse consumers.
  assign w_unused_pulses = ^{w_sw_press, w_sw_release};

endmodule
